// File: rtl/gates_seq_ctrl.sv
// Self-test sequencer for the two-input gates block: walks {a,b} through 00,01,10,11 and checks y1..y5.
// Optional first-mismatch capture is enabled by defining GATES_SEQ_FIRSTFAIL_EN.
module gates_seq_ctrl #(
  parameter int HOLD_CYCLES = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [4:0] y_in,
  output logic       drv_a,
  output logic       drv_b,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [2:0] err_cnt,
  output logic [3:0] err_vec,
  output logic [1:0] vec_idx
`ifdef GATES_SEQ_FIRSTFAIL_EN
  ,
  output logic [6:0] first_fail,
  output logic [4:0] first_fail_y
`endif
);

  localparam int HC_W = $clog2(HOLD_CYCLES + 1);
  localparam logic [HC_W-1:0] HOLD_LAST = HC_W'(HOLD_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    APPLY  = 2'd1,
    SAMPLE = 2'd2,
    DONE   = 2'd3
  } state_t;

  state_t          state_q, state_d;
  logic [HC_W-1:0] cnt_q, cnt_d;
  logic [1:0]      idx_q, idx_d;
  logic [1:0]      drv_q, drv_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic            pass_q, pass_d;
  logic [2:0]      err_cnt_q, err_cnt_d;
  logic [3:0]      err_vec_q, err_vec_d;
  logic            mismatch;

  // Expected {y5,y4,y3,y2,y1} = {NOR,NAND,XOR,OR,AND} for vector {a,b}
  function automatic logic [4:0] exp_y(input logic [1:0] idx);
    logic [4:0] r;
    case (idx)
      2'd0:    r = 5'b11000;
      2'd1:    r = 5'b01110;
      2'd2:    r = 5'b01110;
      default: r = 5'b00011;
    endcase
    return r;
  endfunction

  assign mismatch = (y_in != exp_y(idx_q));

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    idx_d     = idx_q;
    drv_d     = drv_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    pass_d    = pass_q;
    err_cnt_d = err_cnt_q;
    err_vec_d = err_vec_q;
    case (state_q)
      IDLE: begin
        drv_d  = 2'b00;
        busy_d = 1'b0;
        if (start) begin
          state_d   = APPLY;
          idx_d     = 2'd0;
          cnt_d     = '0;
          busy_d    = 1'b1;
          pass_d    = 1'b0;
          err_cnt_d = 3'd0;
          err_vec_d = 4'd0;
        end
      end
      APPLY: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == HOLD_LAST) begin
          state_d = SAMPLE;
        end
      end
      SAMPLE: begin
        if (mismatch) begin
          err_vec_d[idx_q] = 1'b1;
          err_cnt_d        = err_cnt_q + 3'd1;
        end
        if (idx_q == 2'd3) begin
          // pass reflects the final vector's result, which lands on this same edge
          state_d = DONE;
          done_d  = 1'b1;
          pass_d  = (err_cnt_d == 3'd0);
        end else begin
          state_d = APPLY;
          idx_d   = idx_q + 2'd1;
          cnt_d   = '0;
          drv_d   = idx_q + 2'd1;
        end
      end
      DONE: begin
        state_d = IDLE;
        busy_d  = 1'b0;
        drv_d   = 2'b00;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      idx_q     <= 2'd0;
      drv_q     <= 2'b00;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      pass_q    <= 1'b0;
      err_cnt_q <= 3'd0;
      err_vec_q <= 4'd0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      idx_q     <= idx_d;
      drv_q     <= drv_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      pass_q    <= pass_d;
      err_cnt_q <= err_cnt_d;
      err_vec_q <= err_vec_d;
    end
  end

  assign drv_a   = drv_q[1];
  assign drv_b   = drv_q[0];
  assign busy    = busy_q;
  assign done    = done_q;
  assign pass    = pass_q;
  assign err_cnt = err_cnt_q;
  assign err_vec = err_vec_q;
  assign vec_idx = idx_q;

`ifdef GATES_SEQ_FIRSTFAIL_EN
  logic       ff_vld_q, ff_vld_d;
  logic [1:0] ff_idx_q, ff_idx_d;
  logic [4:0] ff_y_q, ff_y_d;

  // Only the first mismatching sample of a run is kept
  always_comb begin
    ff_vld_d = ff_vld_q;
    ff_idx_d = ff_idx_q;
    ff_y_d   = ff_y_q;
    if (state_q == IDLE && start) begin
      ff_vld_d = 1'b0;
      ff_idx_d = 2'd0;
      ff_y_d   = 5'd0;
    end else if (state_q == SAMPLE && mismatch && !ff_vld_q) begin
      ff_vld_d = 1'b1;
      ff_idx_d = idx_q;
      ff_y_d   = y_in;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ff_vld_q <= 1'b0;
      ff_idx_q <= 2'd0;
      ff_y_q   <= 5'd0;
    end else begin
      ff_vld_q <= ff_vld_d;
      ff_idx_q <= ff_idx_d;
      ff_y_q   <= ff_y_d;
    end
  end

  assign first_fail   = {ff_vld_q, ff_idx_q, 4'b0000};
  assign first_fail_y = ff_y_q;
`endif

endmodule
